// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage. Issues word addresses to a synchronous
//   instruction ROM (one-cycle read latency) and presents the fetched
//   (pc, instr) pairs to decode through a valid/ready handshake.
//   Entries move through three places:
//     - one ROM read in flight (req_valid / req_pc)
//     - an output register (out_valid / out_instr / out_pc)
//     - a one-entry skid register (skid_valid / skid_instr / skid_pc)
//   A read is only issued when there is guaranteed room for its data, so the
//   returning word always has a home and nothing is dropped or repeated.
//
// Parameters
//   RESET_PC        word-aligned PC fetched first after reset
// Ports
//   clk_in          clock, rising edge
//   rst_in          asynchronous active-high reset
//   redirect_in     branch/jump redirect strobe (pulse or level)
//   redirect_pc_in  redirect target; bits [1:0] are ignored
//   rom_addr_out    byte address to the ROM (4 KiB window, word aligned)
//   rom_instr_in    ROM data, one edge after rom_addr_out was sampled
//   instr_valid_out instr_out/pc_out hold a fetched instruction
//   instr_out       fetched instruction word
//   pc_out          full 32-bit PC of instr_out
//   dec_ready_in    decode accepts the current instruction this edge
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic [11:0] rom_addr_out,
  input  logic [31:0] rom_instr_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic        dec_ready_in
);

  logic [31:0] pc;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic [31:0] target_pc;
  logic [31:0] issue_pc;
  logic        consume;
  logic [1:0]  occupancy;
  logic        issue_en;

  assign target_pc    = redirect_pc_in & ~32'h3;
  assign issue_pc     = redirect_in ? target_pc : pc;
  assign rom_addr_out = issue_pc[11:0] & ~12'h3;
  assign consume      = out_valid & dec_ready_in;

  // Entries that will still be held after this edge. At most three of
  // out/skid/req can be set, so two bits suffice, and consume implies
  // out_valid so the subtraction never underflows. A new read is only
  // issued while fewer than two entries remain, which keeps
  // out + skid + in-flight <= 2 at all times.
  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid}
                   + {1'b0, req_valid} - {1'b0, consume};
  assign issue_en  = redirect_in | (occupancy < 2'd2);

  assign instr_valid_out = out_valid;
  assign instr_out       = out_instr;
  assign pc_out          = out_pc;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc         <= RESET_PC;
      req_valid  <= 1'b0;
      req_pc     <= 32'h0;
      out_valid  <= 1'b0;
      out_instr  <= 32'h0;
      out_pc     <= 32'h0;
      skid_valid <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
    end else begin
      if (issue_en) begin
        req_valid <= 1'b1;
        req_pc    <= issue_pc;
        pc        <= issue_pc + 32'd4;
      end else begin
        req_valid <= 1'b0;
      end

      // A redirect squashes everything still queued. A transfer on the same
      // edge has already happened from decode's point of view, and the
      // word returning from the old read is simply not captured.
      if (redirect_in) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else if (consume || !out_valid) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_instr  <= skid_instr;
          out_pc     <= skid_pc;
          skid_valid <= req_valid;
          if (req_valid) begin
            skid_instr <= rom_instr_in;
            skid_pc    <= req_pc;
          end
        end else begin
          out_valid <= req_valid;
          if (req_valid) begin
            out_instr <= rom_instr_in;
            out_pc    <= req_pc;
          end
        end
      end else if (req_valid) begin
        // Output is stalled and must stay stable: park the returning word.
        skid_valid <= 1'b1;
        skid_instr <= rom_instr_in;
        skid_pc    <= req_pc;
      end
    end
  end

endmodule
